alu_regheap_ctrl: RTL and testbench
===================================

// Module: alu_regheap_ctrl
// PURPOSE
//  Initiator/sequencer for the ALU + register-heap datapath. Accepts RV32 R-type instructions on a
//  valid/ready port and decodes rs1/rs2/rd/funct into read/write addresses and alu_op. Steps the
//  datapath through READ/EXEC/WB strobes, then returns the result and flags on a valid/ready response port.
// PARAMETERS
//  XLEN    32  datapath / instruction width
//  REG_AW  5   register address width
//  OP_W    4   alu_op width
//  FLAG_W  4   ALU flag width
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  instr_valid  in   1       instruction offered
//  instr_ready  out  1       controller can accept (state==IDLE)
//  instr        in   XLEN    R-type instruction
//  r_addr_a     out  REG_AW  rs1 to register heap
//  r_addr_b     out  REG_AW  rs2 to register heap
//  w_addr       out  REG_AW  rd to register heap
//  alu_op       out  OP_W    {funct7[5],funct3}
//  rd_strobe    out  1       register-read clock enable (1-cycle pulse)
//  alu_strobe   out  1       ALU clock enable (1-cycle pulse)
//  w_en         out  1       register write-back enable (1-cycle pulse)
//  res          in   XLEN    ALU result from datapath
//  flags        in   FLAG_W  ALU flags from datapath
//  done_valid   out  1       response valid
//  done_ready   in   1       response accepted
//  done_res     out  XLEN    captured result
//  done_flags   out  FLAG_W  captured flags
//  illegal      out  1       response is for an undecodable instruction
// BEHAVIOUR
//  - FSM states: IDLE -> READ -> EXEC -> WB -> RESP -> IDLE. Accept on instr_valid&&instr_ready (IDLE only);
//    instr is latched and the address/op outputs hold stable from READ through WB.
//  - READ: rd_strobe=1. EXEC: alu_strobe=1. WB: w_en=1 unless rd==0; done_res/done_flags <= res/flags.
//  - RESP: done_valid=1 until done_ready; on handshake -> IDLE. Next accept no earlier than the following cycle.
//  - Latency: accept at edge N; w_en high in cycle N+3; done_valid high from cycle N+4.
//  - Legal: opcode==7'b0110011 and funct7==0, or funct7==7'b0100000 with funct3 in {000,101}.
//    Otherwise IDLE -> RESP directly: no strobes, illegal=1, done_res=0, done_flags=0.
//  - alu_op codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
//  - done_res/done_flags/illegal hold stable while done_valid && !done_ready.
//  - Reset (any state, incl. mid-operation): state=IDLE, all strobes/w_en=0, done_valid=0, illegal=0,
//    done_res=0, done_flags=0, all addresses/alu_op=0. instr_ready=1. Aborted instructions never write back.
// CONFIGURATION
//  ALU_CTRL_PERF_EN defined: adds outputs retired_cnt[31:0] (increments on each legal response handshake)
//    and illegal_cnt[15:0] (increments on each illegal response handshake). Both wrap; both reset to 0.
//  ALU_CTRL_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Shared header alu_defs.vh: ALU op `defines, R-type opcode, FSM state encodings, FLAG_W.
//  - Sub-module rtype_decode (combinational): instr -> rs1, rs2, rd, alu_op, legal.
//  - Top: FSM, instruction/result registers, optional perf counters.
// TESTING
//  1. Hold rst_n=0 -> instr_ready=1, done_valid=0, w_en=0, rd_strobe=0, alu_strobe=0.
//  2. instr=0x002081B3 (add x3,x1,x2), model res=12 -> r_addr_a=1, r_addr_b=2, w_addr=3, alu_op=0000,
//     strobes in cycles N+1/N+2, w_en in cycle N+3, done_valid in cycle N+4 with done_res=12.
//  3. instr=0x40208033 (sub x0,x1,x2) -> alu_op=1000, w_en never asserts, response delivered with res.
//  4. instr=0x00000013 (addi) -> no strobes, done_valid in cycle N+1, illegal=1, done_res=0.
//  5. done_ready=0 for 10 cycles in RESP -> done_valid/done_res stable, instr_ready=0, no new accept.
//  6. rst_n pulsed low during EXEC -> immediate IDLE, w_en stays 0, done_valid=0, then a new instruction runs normally.

Source files
------------

// File: rtl/alu_regheap_ctrl_pkg.sv
// rtl/alu_regheap_ctrl_pkg.sv - shared widths, R-type encodings and FSM states for the ALU sequencer
package alu_regheap_ctrl_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int OP_W_DEF   = 4;
  localparam int FLAG_W_DEF = 4;

  localparam logic [6:0] OPCODE_OP  = 7'b0110011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/alu_regheap_ctrl_rtype_decode.sv
// rtl/alu_regheap_ctrl_rtype_decode.sv - combinational RV32 R-type field split and legality check
module rtype_decode
  import alu_regheap_ctrl_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [XLEN-1:0]   instr,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [OP_W-1:0]   alu_op,
  output logic              legal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign alu_op = {funct7[5], funct3};

  // The alternate funct7 only selects SUB and SRA; any other pairing is undecodable.
  assign legal = (opcode == OPCODE_OP) &&
                 ((funct7 == F7_BASE) ||
                  ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));

endmodule

// File: rtl/alu_regheap_ctrl.sv
// rtl/alu_regheap_ctrl.sv - READ/EXEC/WB sequencer for the ALU + register heap
// ALU_CTRL_PERF_EN adds retired_cnt / illegal_cnt response counters.
module alu_regheap_ctrl
  import alu_regheap_ctrl_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int FLAG_W = FLAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [XLEN-1:0]   instr,
  output logic [REG_AW-1:0] r_addr_a,
  output logic [REG_AW-1:0] r_addr_b,
  output logic [REG_AW-1:0] w_addr,
  output logic [OP_W-1:0]   alu_op,
  output logic              rd_strobe,
  output logic              alu_strobe,
  output logic              w_en,
  input  logic [XLEN-1:0]   res,
  input  logic [FLAG_W-1:0] flags,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [XLEN-1:0]   done_res,
  output logic [FLAG_W-1:0] done_flags,
  output logic              illegal
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [15:0]       illegal_cnt
`endif
);

  state_t              state;
  logic [REG_AW-1:0]   dec_rs1;
  logic [REG_AW-1:0]   dec_rs2;
  logic [REG_AW-1:0]   dec_rd;
  logic [OP_W-1:0]     dec_op;
  logic                dec_legal;

  rtype_decode #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .OP_W   (OP_W)
  ) u_decode (
    .instr  (instr),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .rd     (dec_rd),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  assign instr_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      r_addr_a   <= '0;
      r_addr_b   <= '0;
      w_addr     <= '0;
      alu_op     <= '0;
      rd_strobe  <= 1'b0;
      alu_strobe <= 1'b0;
      w_en       <= 1'b0;
      done_valid <= 1'b0;
      done_res   <= '0;
      done_flags <= '0;
      illegal    <= 1'b0;
    end else begin
      rd_strobe  <= 1'b0;
      alu_strobe <= 1'b0;
      w_en       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_addr_a <= dec_rs1;
            r_addr_b <= dec_rs2;
            w_addr   <= dec_rd;
            alu_op   <= dec_op;
            if (dec_legal) begin
              state     <= ST_READ;
              rd_strobe <= 1'b1;
              illegal   <= 1'b0;
            end else begin
              // Undecodable: skip the datapath and answer with a zeroed response.
              state      <= ST_RESP;
              done_valid <= 1'b1;
              illegal    <= 1'b1;
              done_res   <= '0;
              done_flags <= '0;
            end
          end
        end
        ST_READ: begin
          state      <= ST_EXEC;
          alu_strobe <= 1'b1;
        end
        ST_EXEC: begin
          state <= ST_WB;
          w_en  <= (w_addr != '0);
        end
        ST_WB: begin
          state      <= ST_RESP;
          done_res   <= res;
          done_flags <= flags;
          done_valid <= 1'b1;
        end
        ST_RESP: begin
          if (done_ready) begin
            state      <= ST_IDLE;
            done_valid <= 1'b0;
            illegal    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else if (done_valid && done_ready) begin
      if (illegal) illegal_cnt <= illegal_cnt + 16'd1;
      else         retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_regheap_ctrl.sv
// tb/tb_alu_regheap_ctrl.sv - self-checking bench for alu_regheap_ctrl against an instruction-level model
module tb_alu_regheap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  r_addr_a;
  logic [4:0]  r_addr_b;
  logic [4:0]  w_addr;
  logic [3:0]  alu_op;
  logic        rd_strobe;
  logic        alu_strobe;
  logic        w_en;
  logic [31:0] res;
  logic [3:0]  flags;
  logic        done_valid;
  logic        done_ready;
  logic [31:0] done_res;
  logic [3:0]  done_flags;
  logic        illegal;
`ifdef ALU_CTRL_PERF_EN
  logic [31:0] retired_cnt;
  logic [15:0] illegal_cnt;
`endif

  int checks;
  int errors;
  int exp_retired;
  int exp_illegal;

  alu_regheap_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .r_addr_a    (r_addr_a),
    .r_addr_b    (r_addr_b),
    .w_addr      (w_addr),
    .alu_op      (alu_op),
    .rd_strobe   (rd_strobe),
    .alu_strobe  (alu_strobe),
    .w_en        (w_en),
    .res         (res),
    .flags       (flags),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .done_res    (done_res),
    .done_flags  (done_flags),
    .illegal     (illegal)
`ifdef ALU_CTRL_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .illegal_cnt (illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level meaning of an R-type word.
  function automatic void model_decode(input logic [31:0] ins, output bit legal,
                                       output int rs1, output int rs2, output int rd, output int op);
    int f7, f3;
    f7  = int'(ins >> 25);
    f3  = int'((ins >> 12) & 32'd7);
    rs1 = int'((ins >> 15) & 32'd31);
    rs2 = int'((ins >> 20) & 32'd31);
    rd  = int'((ins >> 7) & 32'd31);
    legal = ((ins & 32'h7f) == 32'h33) && (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
    op  = (f7 == 32 ? 8 : 0) + f3;
  endfunction

  task automatic check_counters();
`ifdef ALU_CTRL_PERF_EN
    checks++;
    if (retired_cnt !== 32'(exp_retired)) begin
      errors++; $display("FAIL retired_cnt got %0d want %0d", retired_cnt, exp_retired);
    end
    checks++;
    if (illegal_cnt !== 16'(exp_illegal)) begin
      errors++; $display("FAIL illegal_cnt got %0d want %0d", illegal_cnt, exp_illegal);
    end
`endif
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic [31:0] wb_res, input int hold);
    bit legal, seen;
    int rs1, rs2, rd, op, exp_k, k, wait_n;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
    model_decode(ins, legal, rs1, rs2, rd, op);
    exp_k = legal ? 4 : 1;
    exp_res = 32'd0;
    exp_flags = 4'd0;
    wait_n = 0;
    while (instr_ready !== 1'b1 && wait_n < 20) begin
      @(posedge clk); #1; wait_n++;
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL ready_timeout got %b want 1", instr_ready);
    end
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom;
    k = 1; seen = 0;
    while (!seen && k <= 8) begin
      checks++;
      if (rd_strobe !== (legal && k == 1)) begin
        errors++; $display("FAIL rd_strobe ins=%h cycle=%0d got %b", ins, k, rd_strobe);
      end
      checks++;
      if (alu_strobe !== (legal && k == 2)) begin
        errors++; $display("FAIL alu_strobe ins=%h cycle=%0d got %b", ins, k, alu_strobe);
      end
      checks++;
      if (w_en !== (legal && k == 3 && rd != 0)) begin
        errors++; $display("FAIL w_en ins=%h cycle=%0d got %b", ins, k, w_en);
      end
      if (legal && k <= 3) begin
        checks++;
        if (r_addr_a !== 5'(rs1) || r_addr_b !== 5'(rs2) || w_addr !== 5'(rd) || alu_op !== 4'(op)) begin
          errors++;
          $display("FAIL decode ins=%h cycle=%0d got a=%0d b=%0d w=%0d op=%b want a=%0d b=%0d w=%0d op=%b",
                   ins, k, r_addr_a, r_addr_b, w_addr, alu_op, rs1, rs2, rd, 4'(op));
        end
      end
      if (done_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (k != exp_k) begin
          errors++; $display("FAIL done_latency ins=%h got cycle %0d want %0d", ins, k, exp_k);
        end
      end else begin
        res = $urandom; flags = 4'($urandom);
        if (k == 3) begin
          res = wb_res; exp_res = wb_res; exp_flags = flags;
        end
        @(posedge clk); #1; k++;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL done_timeout ins=%h got no response want done_valid", ins);
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (done_valid !== 1'b1 || done_res !== exp_res || done_flags !== exp_flags || illegal !== !legal) begin
        errors++;
        $display("FAIL response ins=%h hold=%0d got v=%b res=%h fl=%h ill=%b want v=1 res=%h fl=%h ill=%b",
                 ins, h, done_valid, done_res, done_flags, illegal, exp_res, exp_flags, !legal);
      end
      checks++;
      if (instr_ready !== 1'b0 || rd_strobe !== 1'b0) begin
        errors++; $display("FAIL resp_busy hold=%0d got ready=%b rd=%b want 0 0", h, instr_ready, rd_strobe);
      end
      if (h < hold) begin
        instr_valid = 1'b1; instr = 32'h002081B3; res = $urandom; flags = 4'($urandom);
        @(posedge clk); #1;
      end
    end
    instr_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    if (legal) exp_retired++; else exp_illegal++;
    checks++;
    if (done_valid !== 1'b0 || instr_ready !== 1'b1) begin
      errors++; $display("FAIL handshake got v=%b ready=%b want 0 1", done_valid, instr_ready);
    end
    check_counters();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (instr_ready !== 1'b1 || done_valid !== 1'b0 || w_en !== 1'b0 || rd_strobe !== 1'b0 || alu_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b v=%b we=%b rs=%b as=%b want 1 0 0 0 0",
               instr_ready, done_valid, w_en, rd_strobe, alu_strobe);
    end
    checks++;
    if (done_res !== 32'd0 || done_flags !== 4'd0 || illegal !== 1'b0 ||
        r_addr_a !== 5'd0 || r_addr_b !== 5'd0 || w_addr !== 5'd0 || alu_op !== 4'd0) begin
      errors++; $display("FAIL reset_data got res=%h fl=%h ill=%b op=%b want zeros", done_res, done_flags, illegal, alu_op);
    end
    exp_retired = 0; exp_illegal = 0;
    check_counters();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    run_instr(32'h002081B3, 32'd12, 0);
  endtask

  task automatic test_sub_x0();
    run_instr(32'h40208033, $urandom, 0);
  endtask

  task automatic test_illegal();
    run_instr(32'h00000013, $urandom, 0);
    run_instr(32'h4020C0B3, $urandom, 0);
  endtask

  task automatic test_backpressure();
    run_instr(32'h0062C2B3, $urandom, 10);
  endtask

  task automatic test_reset_mid_exec();
    instr = 32'h00A50533; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_strobe !== 1'b1) begin
      errors++; $display("FAIL mid_exec_strobe got %b want 1", alu_strobe);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || done_valid !== 1'b0 || alu_strobe !== 1'b0) begin
      errors++; $display("FAIL mid_reset got rdy=%b v=%b as=%b want 1 0 0", instr_ready, done_valid, alu_strobe);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (w_en !== 1'b0 || done_valid !== 1'b0) begin
        errors++; $display("FAIL mid_reset_hold cycle=%0d got we=%b v=%b want 0 0", i, w_en, done_valid);
      end
    end
    rst_n = 1'b1;
    exp_retired = 0; exp_illegal = 0;
    check_counters();
    @(posedge clk); #1;
    run_instr(32'h00A50533, $urandom, 1);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [2:0]  f3;
    logic        alt;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        ins = $urandom;
      end else begin
        alt = 1'($urandom);
        f3  = 3'($urandom);
        if (alt && $urandom_range(0, 1) == 1) f3 = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd0;
        ins = {alt ? 7'b0100000 : 7'b0000000, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
      end
      run_instr(ins, $urandom, $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_instr({7'b0000000, 5'(i + 1), 5'(i + 2), 3'(i), 5'(i + 3), 7'b0110011}, $urandom, 0);
  endtask

  initial begin
    checks = 0; errors = 0; exp_retired = 0; exp_illegal = 0;
    rst_n = 1'b0; instr_valid = 1'b0; instr = 32'd0;
    res = 32'd0; flags = 4'd0; done_ready = 1'b0;
    #1;
    test_reset();
    test_add();
    test_sub_x0();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
